// File: rtl/pc_select_unit.sv
// Registered program-counter unit: N-way next-PC select with stall, a programmable trap
// vector, EPC/cause capture, trap return and a RUN/TRAP/HALT state machine.
module pc_select_unit #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned NSRC        = 4,
  parameter int unsigned INC         = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TVEC_RST = 64'h100,
  parameter bit          ALIGN_CHECK = 1'b1,
  localparam int unsigned SELW       = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pc_en,
  input  logic [SELW-1:0]          pc_sel,
  input  logic [(NSRC-1)*XLEN-1:0] src_addr,
  input  logic                     exc_valid,
  input  logic                     eret,
  input  logic                     tvec_we,
  input  logic [XLEN-1:0]          tvec_wdata,
  output logic [XLEN-1:0]          pc,
  output logic [XLEN-1:0]          epc,
  output logic [1:0]               cause,
  output logic                     in_trap,
  output logic                     halted,
  output logic                     sel_err
);

  localparam logic [XLEN-1:0] INC_V    = XLEN'(INC);
  localparam logic [XLEN-1:0] ALIGN_MK = XLEN'(3);

  typedef enum logic [1:0] {
    S_RUN,
    S_TRAP,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    C_NONE   = 2'd0,
    C_EXT    = 2'd1,
    C_MISALN = 2'd2,
    C_DOUBLE = 2'd3
  } cause_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q, epc_q, tvec_q;
  cause_e          cause_q;
  logic            sel_err_q;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target;
  logic            sel_oob;
  logic            misalign;

  always_comb begin
    seq_pc  = pc_q + INC_V;
    sel_oob = (32'(pc_sel) >= NSRC);
    target  = seq_pc;
    for (int unsigned k = 1; k < NSRC; k++) begin
      if (32'(pc_sel) == k) target = src_addr[(k-1)*XLEN +: XLEN];
    end
    misalign = ALIGN_CHECK && (pc_sel != '0) && !sel_oob && (target[1:0] != 2'b00);
  end

  // Decisions follow the fixed priority: exception, eret, bad select, misalignment, select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      pc_q      <= RESET_PC;
      epc_q     <= '0;
      cause_q   <= C_NONE;
      tvec_q    <= TVEC_RST;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= 1'b0;
      if (tvec_we) tvec_q <= tvec_wdata & ~ALIGN_MK;
      if (pc_en) begin
        case (state_q)
          S_RUN: begin
            if (exc_valid) begin
              pc_q    <= tvec_q;
              epc_q   <= pc_q;
              cause_q <= C_EXT;
              state_q <= S_TRAP;
            end else if (eret) begin
              pc_q <= seq_pc;
            end else if (sel_oob) begin
              sel_err_q <= 1'b1;
            end else if (misalign) begin
              pc_q    <= tvec_q;
              epc_q   <= pc_q;
              cause_q <= C_MISALN;
              state_q <= S_TRAP;
            end else begin
              pc_q <= target;
            end
          end
          S_TRAP: begin
            if (exc_valid) begin
              cause_q <= C_DOUBLE;
              state_q <= S_HALT;
            end else if (eret) begin
              pc_q    <= epc_q;
              cause_q <= C_NONE;
              state_q <= S_RUN;
            end else if (sel_oob) begin
              sel_err_q <= 1'b1;
            end else if (misalign) begin
              cause_q <= C_DOUBLE;
              state_q <= S_HALT;
            end else begin
              pc_q <= target;
            end
          end
          S_HALT: ;
          default: state_q <= S_HALT;
        endcase
      end
    end
  end

  assign pc      = pc_q;
  assign epc     = epc_q;
  assign cause   = cause_q;
  assign in_trap = (state_q == S_TRAP);
  assign halted  = (state_q == S_HALT);
  assign sel_err = sel_err_q;

endmodule
